// File: rtl/iterative_shift_unit.sv
// Purpose : iterative left / logical-right / arithmetic-right shifter, one bit position per clock.
// Latency : result valid N+1 cycles after acceptance (N = shift amount); back-to-back accept from DONE.
// Backpressure: result held stable and in_ready low while out_valid && !out_ready.
module iterative_shift_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_arith,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] data_r;
    logic [AMT_W-1:0] cnt_r;
    logic             dir_r;
    logic             arith_r;
    logic             w_accept;
    logic             w_fill;

    assign w_accept = in_valid && in_ready;
    // Bit shifted in at the top on right shifts: sign bit only for arithmetic.
    assign w_fill   = arith_r & data_r[WIDTH-1];

    // State register; reset aborts any shift in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE can hand off straight to a new request.
    always_comb begin
        w_state_nxt = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (in_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt_r == AMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = (in_amt == '0) ? S_DONE : S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then one bit step and count-down per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            cnt_r   <= '0;
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
        end else if (w_accept) begin
            data_r  <= in_data;
            cnt_r   <= in_amt;
            dir_r   <= in_dir;
            arith_r <= in_arith && in_dir;
        end else if (state == S_SHIFT) begin
            if (dir_r) begin
                data_r <= {w_fill, data_r[WIDTH-1:1]};
            end else begin
                data_r <= {data_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r - AMT_W'(1);
        end
    end

    // Result is exposed only in DONE so the bus reads zero otherwise.
    assign out_data = (state == S_DONE) ? data_r : '0;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Purpose : directed bench for iterative_shift_unit with queue scoreboard and independent monitor.
// Latency : expected result cycle = acceptance cycle + 1 + amount, checked per result.
// Backpressure: holds out_ready low to check result stability and in_ready gating.
module tb_iterative_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_dir;
    logic        in_arith;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    iterative_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   busy_cnt  = 0;
    int   n_results = 0;
    int   first_vld = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks held results.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
            n_results++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none (cycle %0d)", out_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("result_data", out_data, e.d);
                chk("result_valid_cycle", first_vld, e.cyc);
            end
            first_vld = -1;
        end else if (out_valid && !out_ready && sb.size() > 0) begin
            chk("held_data_stable", out_data, sb[0].d);
            chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic send(input logic [31:0] d, input logic dir, input logic arith,
                        input logic [4:0] amt, input logic [31:0] exp_d, output int acc_cyc);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_arith = arith;
        in_amt   = amt;
        acc_cyc  = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                e.d     = exp_d;
                e.cyc   = cyc + 1 + int'(amt);
                sb.push_back(e);
                break;
            end
        end
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted data=%h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        in_arith = 1'b0;
        in_amt   = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        int rdy_cyc;
        int nres;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        in_amt    = '0;
        out_ready = 1'b1;
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset abort in the middle of a 20-bit shift.
        send(32'h0000_0001, 1'b0, 1'b0, 5'd20, 32'h0010_0000, a);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        nres = n_results;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_result", n_results, nres);

        // Full-range left shift.
        busy_cnt = 0;
        send(32'h0000_0001, 1'b0, 1'b0, 5'd31, 32'h8000_0000, a);
        drain();
        chk("busy_cycles_amt31", busy_cnt, 32'd31);

        // Right arithmetic, right logical, left with arith ignored.
        send(32'h8000_00F0, 1'b1, 1'b1, 5'd4, 32'hF800_000F, a);
        send(32'h8000_00F0, 1'b1, 1'b0, 5'd4, 32'h0800_000F, a);
        send(32'h8000_0001, 1'b0, 1'b1, 5'd1, 32'h0000_0002, a);
        drain();

        // Zero amount.
        busy_cnt = 0;
        send(32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, a);
        drain();
        chk("busy_cycles_amt0", busy_cnt, 32'd0);

        // Back-pressure for 5 cycles, then hand-off in the same cycle out_ready rises.
        out_ready = 1'b0;
        send(32'h0000_0001, 1'b0, 1'b0, 5'd8, 32'h0000_0100, a);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        rdy_cyc = -1;
        fork
            send(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd16, 32'h0000_FFFF, a2);
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                rdy_cyc   = cyc;
            end
        join
        chk("b2b_accept_cycle", a2, rdy_cyc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
